mcycle_ctrl: RTL
================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum number of memory wait cycles before a fault.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 opcode  in  6 and funct  in  6: fields of the instruction register.
REQ-006 zero  in  1: ALU zero flag.
REQ-007 mem_ready  in  1: memory completes the current access this cycle.
REQ-008 mem_req, mem_we, mem_sel  out  1 each: access request, write, address select (0=PC, 1=ALU register).
REQ-009 pc_we, ir_we, mdr_we, ab_we, reg_we  out  1 each: register enables.
REQ-010 reg_dst  out  2 (0=rd, 1=rt, 2=r31); mem_to_reg  out  2 (0=ALU register, 1=MDR, 2=PC).
REQ-011 alu_src_a  out  1 (0=PC, 1=A); alu_src_b  out  2 (0=B, 1=4, 2=sext imm, 3=sext imm<<2); alu_op  out  3.
REQ-012 pc_src  out  2 (0=ALU result, 1=ALU register, 2=jump concat, 3=A).
REQ-013 fault  out  1; instret  out  CNT_W; state  out  4.

Function
REQ-014 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, JAL, JR, FAULT. The external ALU result register loads every cycle.
REQ-015 Every output not explicitly asserted in a state SHALL be 0.
REQ-016 FETCH: mem_req=1, mem_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. On mem_ready: ir_we=1, pc_we=1, pc_src=0, next state DECODE; otherwise stay in FETCH.
REQ-017 DECODE: ab_we=1, alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target). Next state by opcode:
  - 0x00: funct 0x08 -> JR, else EXEC_R
  - LW 0x23 / SW 0x2B -> MEM_ADDR
  - ADDI 0x08 / XORI 0x0E -> EXEC_I
  - BEQ 0x04 / BNE 0x05 -> BRANCH
  - J 0x02 -> JUMP
  - JAL 0x03 -> see REQ-030
  - anything else -> FAULT
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; next state MEM_RD for LW, MEM_WR for SW.
REQ-019 MEM_RD: mem_req=1, mem_sel=1; on mem_ready: mdr_we=1, next state MEM_WB. MEM_WB: reg_we=1, reg_dst=1, mem_to_reg=1, next state FETCH.
REQ-020 MEM_WR: mem_req=1, mem_we=1, mem_sel=1; on mem_ready, next state FETCH.
REQ-021 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct (0x20 ADD, 0x22 SUB, 0x2A SLT, 0x26 XOR); an unknown funct goes to FAULT. WB_R: reg_we=1, reg_dst=0, mem_to_reg=0, next state FETCH.
REQ-022 EXEC_I: alu_src_a=1, alu_src_b=2, alu_op ADD or XOR. WB_I: reg_we=1, reg_dst=1, next state FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_we=(BEQ&zero)|(BNE&!zero). Next state FETCH.
REQ-024 JUMP: pc_we=1, pc_src=2. JR: pc_we=1, pc_src=3. Both go to FETCH.
REQ-025 Wait counter: counts cycles with mem_req=1 and mem_ready=0, and clears on every state change. When the count reaches MEM_TIMEOUT, next state is FAULT. mem_ready arriving in the same cycle wins over the timeout.
REQ-026 FAULT is sticky until reset: fault=1, all enables 0.
REQ-027 instret increments by 1 on each transition into FETCH from any non-FETCH state, and wraps modulo 2^CNT_W.

Reset
REQ-028 Reset low immediately forces state=FETCH, instret=0, wait counter=0 and all outputs 0, including mem_req, so any access in flight is abandoned. This applies mid-access as well.
REQ-029 After reset is released, the first rising edge evaluates FETCH normally.

Configuration
REQ-030 Macro MCYCLE_CTRL_JAL_EN.
  - Defined: JAL opcode goes to the JAL state. JAL asserts reg_we=1, reg_dst=2, mem_to_reg=2 (PC already +4), pc_we=1, pc_src=2, then goes to FETCH.
  - Undefined: the JAL state is absent and the JAL opcode goes to FAULT.

Structure
REQ-031 Package mcycle_ctrl_pkg holds:
  - the state encoding
  - the opcode and funct constants
  - the ALU op codes (ADD=0, SUB=1, XOR=2, SLT=3)
  - the mux select encodings
REQ-032 One sub-module, mcycle_ctrl_wdog, holds the wait counter and the timeout compare.

Verification
REQ-033 LW, opcode 0x23, with mem_ready held high: FETCH->DECODE->MEM_ADDR->MEM_RD->MEM_WB->FETCH in 5 cycles; mdr_we pulses once; instret goes 0->1.
REQ-034 BEQ with zero=1 gives pc_we=1 in BRANCH; BNE with zero=1 gives pc_we=0. Both return to FETCH.
REQ-035 mem_ready held low in FETCH with MEM_TIMEOUT=15: fault=1 after 15 wait cycles. mem_ready rising exactly on wait cycle 15 goes to DECODE, not FAULT.
REQ-036 Opcode 0x3F, and R-type with funct 0x3F: both reach FAULT and stay there for 20 cycles.
REQ-037 JAL with the macro defined: reg_dst=2 and pc_src=2 in the JAL state. Without the macro: FAULT.
REQ-038 Reset asserted during MEM_WR with mem_req=1: mem_req drops to 0 without waiting for a clock edge; state=FETCH; instret=0.

Source files
------------

// File: rtl/mcycle_ctrl_pkg.sv
// rtl/mcycle_ctrl_pkg.sv - state encoding, opcode/funct constants, ALU ops and mux selects for mcycle_ctrl
// Optional build macro: MCYCLE_CTRL_JAL_EN adds the S_JAL state.
package mcycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
`ifdef MCYCLE_CTRL_JAL_EN
        S_JAL      = 4'd12,
`endif
        S_JR       = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic       SEL_PC  = 1'b0;
    localparam logic       SEL_ALU = 1'b1;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_4       = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_A      = 2'd3;

    localparam logic [1:0] DST_RD  = 2'd0;
    localparam logic [1:0] DST_RT  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // Returns {valid, alu_op} for an R-type funct field.
    function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            FN_ADD:  r_alu_op = {1'b1, ALU_ADD};
            FN_SUB:  r_alu_op = {1'b1, ALU_SUB};
            FN_XOR:  r_alu_op = {1'b1, ALU_XOR};
            FN_SLT:  r_alu_op = {1'b1, ALU_SLT};
            default: r_alu_op = {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/mcycle_ctrl_wdog.sv
// rtl/mcycle_ctrl_wdog.sv - memory wait-cycle counter with timeout compare
// Ports: clk, reset (async active-low), access (memory request this cycle),
//        mem_ready, clear (state is changing), expire (this wait cycle is the last allowed).
module mcycle_ctrl_wdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic access,
    input  logic mem_ready,
    input  logic clear,
    output logic expire
);

    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt;
    logic         waiting;

    assign waiting = access & ~mem_ready;
    // The wait cycle that would bring the count to MEM_TIMEOUT is the one that faults.
    assign expire  = waiting && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - multi-cycle MIPS-subset control FSM with memory wait timeout
// Optional build macro: MCYCLE_CTRL_JAL_EN (JAL state; otherwise JAL faults).
// Ports: clk, reset (async active-low); opcode, funct, zero, mem_ready in;
//        memory controls, register enables, mux selects, alu_op, fault, instret, state out.
module mcycle_ctrl
    import mcycle_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             ab_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             fault,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    state_t     state_q, state_d;
    logic       access;
    logic       expire;
    logic [3:0] r_dec;

    // Derived straight from the state so the watchdog path does not loop through the output block.
    assign access = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign r_dec  = r_alu_op(funct);
    assign state  = state_q;

    mcycle_ctrl_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .access    (access),
        .mem_ready (mem_ready),
        .clear     (state_d != state_q),
        .expire    (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != S_FETCH && state_d == S_FETCH) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = SEL_PC;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        ab_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RD;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_4;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (expire) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                ab_we     = 1'b1;
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:        state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_ADDI, OP_XORI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
`ifdef MCYCLE_CTRL_JAL_EN
                    OP_JAL:          state_d = S_JAL;
`else
                    OP_JAL:          state_d = S_FAULT;
`endif
                    default:         state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                mem_sel = SEL_ALU;
                if (mem_ready) begin
                    mdr_we  = 1'b1;
                    state_d = S_MEM_WB;
                end else if (expire) begin
                    state_d = S_FAULT;
                end
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                reg_dst    = DST_RT;
                mem_to_reg = M2R_MDR;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_sel = SEL_ALU;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (expire) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_A;
                alu_op    = r_dec[2:0];
                state_d   = r_dec[3] ? S_WB_R : S_FAULT;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_we  = 1'b1;
                reg_dst = DST_RT;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_A;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_we     = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_src  = PC_JUMP;
                state_d = S_FETCH;
            end
`ifdef MCYCLE_CTRL_JAL_EN
            S_JAL: begin
                reg_we     = 1'b1;
                reg_dst    = DST_R31;
                mem_to_reg = M2R_PC;
                pc_we      = 1'b1;
                pc_src     = PC_JUMP;
                state_d    = S_FETCH;
            end
`endif
            S_JR: begin
                pc_we   = 1'b1;
                pc_src  = PC_A;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Reset drops every output at once, abandoning any access in flight.
        if (!reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_sel    = 1'b0;
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            mdr_we     = 1'b0;
            ab_we      = 1'b0;
            reg_we     = 1'b0;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alu_op     = 3'd0;
            pc_src     = 2'd0;
            fault      = 1'b0;
        end
    end

endmodule
